regfile32_onehot: RTL and testbench
===================================

Name: regfile32_onehot

Overview:
- 32-entry x DW general-purpose register file, directly downstream of the 5-to-32 enabled write-address decoder.
- Consumes the decoder's one-hot 32-bit write-select vector plus write data.
- Provides two asynchronous read ports to the datapath (ALU operands).
- Register 0 is hardwired to zero; malformed (multi-hot) select vectors are blocked and flagged.

Parameters:
- DW, 32, data width of each register and of wd/rd1/rd2.
- NREGS, 32, number of registers. Fixed to match the decoder output width; any other value is unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- we_sel  input  32  one-hot write select from decoder; all-zero = no write
- wd  input  DW  write data
- ra1  input  5  read address, port 1
- ra2  input  5  read address, port 2
- rd1  output  DW  read data, port 1 (combinational from ra1)
- rd2  output  DW  read data, port 2 (combinational from ra2)
- sel_err  output  1  sticky flag: a multi-hot we_sel was seen
- wr_cnt  output  16  count of committed writes (wraps)

Behaviour:
- Reset (rst=1 at posedge):
  - all registers <= 0, sel_err <= 0, wr_cnt <= 0.
  - Any write presented in the reset cycle is discarded.
  - Reset applies mid-operation without restriction; the first write after reset commits at the first edge with rst=0.
- Select validity, evaluated each cycle:
  - valid = we_sel has zero or exactly one bit set.
  - multi = two or more bits set.
- Write: at posedge with rst=0, valid=1 and we_sel[i]=1 for i!=0, reg[i] <= wd. Write latency 1 cycle.
- we_sel[0]=1 alone: no write, reg0 stays 0. Counts as valid; wr_cnt is not incremented.
- multi=1: no register changes, sel_err <= 1. sel_err stays set until rst; no other path clears it.
- wr_cnt increments by 1 on each committed write to reg 1..31. Wraps 0xFFFF -> 0x0000 with no flag.
- Reads:
  - rd1 = (ra1==0) ? 0 : reg[ra1]; rd2 likewise for ra2.
  - Both ports are fully independent; ra1==ra2 is legal.
- Read during write to the same index: rd shows the old value until the edge, unless the bypass feature is enabled (see Optional Feature).
- No X propagation from unwritten registers; reset guarantees defined contents.

Optional Feature:
- Macro: REGFILE32_BYPASS_EN.
- Defined: write-through forwarding. If valid=1, rst=0, we_sel[k]=1 with k!=0, and ra1==k, then rd1 = wd in the same cycle. Same rule for rd2/ra2.
  - No forwarding when multi=1, during reset, or for index 0.
- Undefined: rd1/rd2 always reflect stored contents (old value during the write cycle).
- Storage, sel_err and wr_cnt behaviour are identical either way.

Decomposition:
- Package regfile_pkg holds:
  - constants NREGS=32, AW=5, DW_DEF=32, REG_ZERO=0, WRCNT_W=16
  - typedef data_t (DW_DEF bits)
  - typedef sel_t (32 bits)
- One sub-module, onehot_chk: combinational, input sel_t, outputs valid and multi, plus the 5-bit encoded index (used for wr_cnt gating and bypass compare).
- Storage array and read muxes stay in the top module.

Test Plan:
- Reset: write 0xFFFFFFFF to all regs, assert rst 1 cycle -> every rd = 0, sel_err=0, wr_cnt=0; a write presented with rst=1 is not stored.
- Basic write/read: we_sel=0x00000020, wd=0xDEADBEEF; next cycle ra1=5 -> rd1=0xDEADBEEF, wr_cnt=1; ra2=6 -> rd2=0.
- Register 0: we_sel=0x00000001, wd=0x12345678 -> ra1=0 gives rd1=0, wr_cnt unchanged, sel_err=0.
- Multi-hot: reg3=0xA5A5A5A5, then we_sel=0x00000018, wd=0x1 -> reg3=0xA5A5A5A5, reg4 unchanged, sel_err=1 held over 10 idle cycles; cleared only by rst.
- Same-cycle read/write: reg7=0x11, we_sel=0x00000080, wd=0x22, ra1=ra2=7 in that cycle -> rd1=rd2=0x22 with REGFILE32_BYPASS_EN, 0x11 without; 0x22 after the edge in both builds.
- Counter wrap: 65536 committed writes to reg 1 -> wr_cnt returns to 0x0000; final value readable at ra1=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the one-hot register file.
// Optional write-through forwarding in the top: REGFILE32_BYPASS_EN.
package regfile_pkg;
  localparam int NREGS    = 32;
  localparam int AW       = 5;
  localparam int DW_DEF   = 32;
  localparam int REG_ZERO = 0;
  localparam int WRCNT_W  = 16;

  typedef logic [DW_DEF-1:0] data_t;
  typedef logic [NREGS-1:0]  sel_t;
endpackage

// File: rtl/regfile32_onehot_onehot_chk.sv
// Select-vector checker: flags zero/one-hot vs multi-hot and encodes the index.
// Index is only meaningful when the vector is one-hot.
module onehot_chk
  import regfile_pkg::*;
(
  input  sel_t          sel,
  output logic          valid,
  output logic          multi,
  output logic [AW-1:0] idx
);

  // x & (x-1) clears the lowest set bit; anything left means 2+ bits
  always_comb begin
    multi = |(sel & (sel - sel_t'(1)));
    valid = !multi;
  end

  always_comb begin
    idx = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (sel[i]) idx = idx | AW'(i);
    end
  end

endmodule

// File: rtl/regfile32_onehot.sv
// 32 x DW register file driven by a one-hot write select, two async reads.
// Define REGFILE32_BYPASS_EN for same-cycle write-through forwarding.
module regfile32_onehot
  import regfile_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int NREGS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREGS-1:0]   we_sel,
  input  logic [DW-1:0]      wd,
  input  logic [AW-1:0]      ra1,
  input  logic [AW-1:0]      ra2,
  output logic [DW-1:0]      rd1,
  output logic [DW-1:0]      rd2,
  output logic               sel_err,
  output logic [WRCNT_W-1:0] wr_cnt
);

  logic [DW-1:0]      regs_q [NREGS];
  logic [DW-1:0]      regs_d [NREGS];
  logic               sel_err_q, sel_err_d;
  logic [WRCNT_W-1:0] wr_cnt_q, wr_cnt_d;

  logic          valid;
  logic          multi;
  logic [AW-1:0] idx;
  logic          commit;

  onehot_chk u_chk (
    .sel   (we_sel),
    .valid (valid),
    .multi (multi),
    .idx   (idx)
  );

  assign commit = valid && (idx != AW'(REG_ZERO));

  always_comb begin
    regs_d    = regs_q;
    sel_err_d = sel_err_q;
    wr_cnt_d  = wr_cnt_q;
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_d[i] = '0;
      sel_err_d = 1'b0;
      wr_cnt_d  = '0;
    end else begin
      if (multi) sel_err_d = 1'b1;
      if (commit) begin
        regs_d[idx] = wd;
        wr_cnt_d    = wr_cnt_q + 1'b1;
      end
    end
    regs_d[REG_ZERO] = '0;
  end

  always_ff @(posedge clk) begin
    regs_q    <= regs_d;
    sel_err_q <= sel_err_d;
    wr_cnt_q  <= wr_cnt_d;
  end

  always_comb begin
    rd1 = regs_q[ra1];
    rd2 = regs_q[ra2];
`ifdef REGFILE32_BYPASS_EN
    if (!rst && commit && ra1 == idx) rd1 = wd;
    if (!rst && commit && ra2 == idx) rd2 = wd;
`endif
    if (ra1 == AW'(REG_ZERO)) rd1 = '0;
    if (ra2 == AW'(REG_ZERO)) rd2 = '0;
  end

  assign sel_err = sel_err_q;
  assign wr_cnt  = wr_cnt_q;

endmodule

// File: tb/tb_regfile32_onehot.sv
// Scoreboard bench for regfile32_onehot: stimulus pushes expectations,
// a negedge monitor pops and compares them.
module tb_regfile32_onehot;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] we_sel;
  logic [31:0] wd;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1, rd2;
  logic        sel_err;
  logic [15:0] wr_cnt;

  regfile32_onehot dut (
    .clk     (clk),
    .rst     (rst),
    .we_sel  (we_sel),
    .wd      (wd),
    .ra1     (ra1),
    .ra2     (ra2),
    .rd1     (rd1),
    .rd2     (rd2),
    .sel_err (sel_err),
    .wr_cnt  (wr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  en;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t  exp_q [$];
  string name_q [$];
  int    checks = 0;
  int    errors = 0;

  localparam logic [3:0] E_R1 = 4'b0001;
  localparam logic [3:0] E_R2 = 4'b0010;
  localparam logic [3:0] E_ER = 4'b0100;
  localparam logic [3:0] E_CN = 4'b1000;

  task automatic cyc(input logic r, input logic [31:0] s,
                     input logic [31:0] d,
                     input logic [4:0] a1, input logic [4:0] a2);
    @(posedge clk);
    #1;
    rst = r; we_sel = s; wd = d; ra1 = a1; ra2 = a2;
  endtask

  task automatic push(input string nm, input logic [3:0] en,
                      input logic [31:0] e1, input logic [31:0] e2,
                      input logic ee, input logic [15:0] ec);
    exp_t e;
    e.en = en; e.rd1 = e1; e.rd2 = e2; e.err = ee; e.cnt = ec;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // monitor
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.en[0]) begin
          checks++;
          if (rd1 !== e.rd1) begin
            errors++;
            $display("FAIL %s rd1: got %h want %h", nm, rd1, e.rd1);
          end
        end
        if (e.en[1]) begin
          checks++;
          if (rd2 !== e.rd2) begin
            errors++;
            $display("FAIL %s rd2: got %h want %h", nm, rd2, e.rd2);
          end
        end
        if (e.en[2]) begin
          checks++;
          if (sel_err !== e.err) begin
            errors++;
            $display("FAIL %s sel_err: got %b want %b", nm, sel_err, e.err);
          end
        end
        if (e.en[3]) begin
          checks++;
          if (wr_cnt !== e.cnt) begin
            errors++;
            $display("FAIL %s wr_cnt: got %h want %h", nm, wr_cnt, e.cnt);
          end
        end
      end
    end
  end

  logic [31:0] byp;
  int          wait_n;

  initial begin
    rst = 1'b1; we_sel = '0; wd = '0; ra1 = '0; ra2 = '0;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 31);
    push("post_reset", E_R1 | E_R2 | E_ER | E_CN, 0, 0, 0, 0);

    // fill all registers with ones
    for (int i = 1; i < 32; i++) cyc(0, 32'h1 << i, 32'hFFFF_FFFF, 0, 0);
    cyc(0, 0, 0, 1, 31);
    push("fill", E_R1 | E_R2 | E_CN, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 16'd31);

    // reset with a write presented: write is discarded
    cyc(1, 32'h1 << 9, 32'h55, 0, 0);
    for (int i = 1; i < 32; i += 2) begin
      cyc(0, 0, 0, 5'(i), 5'(i + 1));
      push("reset_clear", E_R1 | E_R2 | E_ER | E_CN, 0, 0, 0, 0);
    end

    // basic write/read
    cyc(0, 32'h20, 32'hDEAD_BEEF, 0, 0);
    cyc(0, 0, 0, 5, 6);
    push("basic", E_R1 | E_R2 | E_CN, 32'hDEAD_BEEF, 0, 0, 16'd1);

    // register 0
    cyc(0, 32'h1, 32'h1234_5678, 0, 0);
    cyc(0, 0, 0, 0, 5);
    push("reg0", E_R1 | E_R2 | E_ER | E_CN, 0, 32'hDEAD_BEEF, 0, 16'd1);

    // multi-hot
    cyc(0, 32'h8, 32'hA5A5_A5A5, 0, 0);
    cyc(0, 32'h18, 32'h1, 3, 4);
    push("multi_cyc", E_R1 | E_R2 | E_ER, 32'hA5A5_A5A5, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 3, 4);
      push("multi_hold", E_R1 | E_R2 | E_ER | E_CN,
           32'hA5A5_A5A5, 0, 1, 16'd2);
    end
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 3, 5);
    push("err_clear", E_R1 | E_R2 | E_ER | E_CN, 0, 0, 0, 0);

    // same-cycle read/write
`ifdef REGFILE32_BYPASS_EN
    byp = 32'h22;
`else
    byp = 32'h11;
`endif
    cyc(0, 32'h80, 32'h11, 0, 0);
    cyc(0, 32'h80, 32'h22, 7, 7);
    push("rw_same", E_R1 | E_R2 | E_CN, byp, byp, 0, 16'd1);
    cyc(0, 0, 0, 7, 7);
    push("rw_after", E_R1 | E_R2 | E_CN, 32'h22, 32'h22, 0, 16'd2);
    // no forwarding on a multi-hot select
    cyc(0, 32'h180, 32'h33, 7, 8);
    push("no_fwd_multi", E_R1 | E_R2, 32'h22, 0, 0, 0);
    cyc(0, 0, 0, 7, 8);
    push("multi_after", E_R1 | E_R2 | E_ER | E_CN, 32'h22, 0, 1, 16'd2);
    // no forwarding during reset
    cyc(1, 32'h100, 32'h44, 8, 7);
    push("no_fwd_rst", E_R1 | E_R2, 0, 32'h22, 0, 0);

    // counter wrap
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 65536; i++) begin
      cyc(0, 32'h2, 32'(i), 0, 0);
      if (i == 65535) push("cnt_ffff", E_CN, 0, 0, 0, 16'hFFFF);
    end
    cyc(0, 0, 0, 1, 0);
    push("cnt_wrap", E_R1 | E_R2 | E_ER | E_CN, 32'hFFFF, 0, 0, 16'h0000);

    wait_n = 0;
    while (exp_q.size() > 0 && wait_n < 10) begin
      @(posedge clk);
      wait_n++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d pending want 0", exp_q.size());
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
